// File: rtl/nn_mutex_pkg.sv
// nn_mutex_pkg: shared FSM state type and index helper for the layer RAM mutex.
package nn_mutex_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_RELEASE} st_mutex_e;

    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker, first set bit at or after ptr.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);
    logic [IW-1:0] j;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        gnt = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
    end

    assign vld = |req;
endmodule

// File: rtl/layer_ram_mutex.sv
// layer_ram_mutex: round-robin mutex sharing one RAM port between the neurons of a layer,
// with an optional hold timeout that reclaims the port from a stuck owner.
module layer_ram_mutex
    import nn_mutex_pkg::*;
#(
    parameter int NumRequesters = 5,
    parameter int DataWidth     = 8,
    parameter int AddrWidth     = 3,
    parameter int MaxHoldCycles = 0,
    parameter int IdxWidth      = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NumRequesters-1:0]           req_i,
    input  logic [NumRequesters-1:0]           rel_i,
    output logic [NumRequesters-1:0]           grant_o,
    output logic [IdxWidth-1:0]                owner_o,
    output logic                               busy_o,
    output logic                               timeout_o,
    input  logic [NumRequesters*AddrWidth-1:0] req_addr_i,
    input  logic [NumRequesters-1:0]           req_we_i,
    input  logic [NumRequesters*DataWidth-1:0] req_dout_i,
    output logic [AddrWidth-1:0]               ram_addr_o,
    output logic                               ram_we_o,
    output logic [DataWidth-1:0]               ram_dout_o,
    input  logic [DataWidth-1:0]               ram_din_i,
    output logic [DataWidth-1:0]               req_din_o
);
    localparam int CW = (MaxHoldCycles > 1) ? $clog2(MaxHoldCycles) : 1;

    st_mutex_e                state;
    logic [NumRequesters-1:0] pending, cand, win;
    logic                     win_vld, owner_rel, hold_exp, owned;
    logic [IdxWidth-1:0]      ptr, widx;
    logic [CW-1:0]            hold_cnt;

    assign cand = pending | req_i;

    rr_arbiter #(.N(NumRequesters), .IW(IdxWidth)) u_arb (
        .req(cand),
        .ptr(ptr),
        .gnt(win),
        .vld(win_vld)
    );

    assign widx      = IdxWidth'(onehot_to_idx(32'(win)));
    assign owner_rel = rel_i[owner_o];
    assign hold_exp  = (MaxHoldCycles > 0) && (hold_cnt == CW'(MaxHoldCycles - 1));
    assign owned     = (state == ST_OWNED);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            pending   <= '0;
            grant_o   <= '0;
            owner_o   <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout_o <= 1'b0;
            pending   <= cand & ~((state == ST_IDLE && win_vld) ? win : '0);
            case (state)
                ST_IDLE: if (win_vld) begin
                    grant_o  <= win;
                    owner_o  <= widx;
                    busy_o   <= 1'b1;
                    ptr      <= (widx == IdxWidth'(NumRequesters - 1)) ? '0 : widx + 1'b1;
                    hold_cnt <= '0;
                    state    <= ST_OWNED;
                end
                ST_OWNED: if (owner_rel || hold_exp) begin
                    grant_o   <= '0;
                    busy_o    <= 1'b0;
                    timeout_o <= !owner_rel;
                    state     <= ST_RELEASE;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr_o = owned ? req_addr_i[owner_o*AddrWidth +: AddrWidth] : '0;
    assign ram_we_o   = owned ? req_we_i[owner_o] : 1'b0;
    assign ram_dout_o = owned ? req_dout_i[owner_o*DataWidth +: DataWidth] : '0;
    assign req_din_o  = ram_din_i;
endmodule
